// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: moves one cache line between the cache's physical-memory
// port and a narrower burst memory bus. A line read or write is accepted from
// pmem_*, runs as BEATS beats on burst_*, and finishes with a one-cycle
// pmem_resp pulse. All state changes on the rising edge of clk, and rst is a
// synchronous, active-high reset.
module cacheline_adaptor #(
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_burst  = 64,
  parameter int unsigned s_offset = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pmem_read,
  input  logic                pmem_write,
  input  logic [31:0]         pmem_address,
  input  logic [s_line-1:0]   pmem_wdata,
  output logic [s_line-1:0]   pmem_rdata,
  output logic                pmem_resp,
  output logic                burst_read,
  output logic                burst_write,
  output logic [31:0]         burst_addr,
  output logic [s_burst-1:0]  burst_wdata,
  input  logic [s_burst-1:0]  burst_rdata,
  input  logic                burst_resp
);

  localparam int unsigned BEATS = s_line / s_burst;
  localparam int unsigned KW    = $clog2(BEATS);
  localparam logic [KW-1:0] LAST_BEAT = KW'(BEATS - 1);
  // Ones in the line-offset bit positions. These bits are cleared in the burst address.
  localparam logic [31:0] OFFSET_MASK = 32'((64'd1 << s_offset) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     beat_q;
  logic [s_line-1:0] wline_q;
  logic              accept;
  logic              beat_done;

  // A request is taken only in IDLE. A beat is consumed only while a burst is active.
  assign accept    = (state_q == ST_IDLE) && (pmem_read || pmem_write);
  assign beat_done = ((state_q == ST_RD) || (state_q == ST_WR)) && burst_resp;

  // Next-state and Moore outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves any output unassigned would infer a latch.
    state_d     = state_q;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    pmem_resp   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A writeback wins over a fill. The fill stays pending in pmem_read.
        if (pmem_write)     state_d = ST_WR;
        else if (pmem_read) state_d = ST_RD;
      end
      ST_RD: begin
        burst_read = 1'b1;
        if (burst_resp && (beat_q == LAST_BEAT)) state_d = ST_DONE;
      end
      ST_WR: begin
        burst_write = 1'b1;
        if (burst_resp && (beat_q == LAST_BEAT)) state_d = ST_DONE;
      end
      ST_DONE: begin
        // One-cycle completion. No request is accepted here.
        pmem_resp = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and beat counter. The counter wraps to 0 on the final beat.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together at the edge, with no dependence on
    // the order of the statements.
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (beat_done) beat_q <= beat_q + KW'(1);
    end
  end

  // Datapath: latch the request at acceptance and assemble the fill line beat by beat.
  always_ff @(posedge clk) begin
    // NOTE: the wide data registers are reset on purpose. After reset the
    // bus shows zeros, and a fill interrupted by reset leaves no partial
    // line on pmem_rdata.
    if (rst) begin
      burst_addr <= '0;
      wline_q    <= '0;
      pmem_rdata <= '0;
    end else begin
      if (accept) begin
        burst_addr <= pmem_address & ~OFFSET_MASK;
        if (pmem_write) wline_q <= pmem_wdata;
      end
      if ((state_q == ST_RD) && burst_resp)
        pmem_rdata[beat_q*s_burst +: s_burst] <= burst_rdata;
    end
  end

  // The current write beat is the latched line slice chosen by the beat counter.
  assign burst_wdata = wline_q[beat_q*s_burst +: s_burst];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed testbench for cacheline_adaptor. Each task runs one scenario and
// checks the results inline against values worked out by hand.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_addr;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int n_pass  = 0;
  int n_total = 0;

  cacheline_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .burst_read   (burst_read),
    .burst_write  (burst_write),
    .burst_addr   (burst_addr),
    .burst_wdata  (burst_wdata),
    .burst_rdata  (burst_rdata),
    .burst_resp   (burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge. Inputs are then driven, and outputs sampled, 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present four back-to-back read beats taken from line, slice 0 first.
  task automatic drive_beats(input logic [255:0] line);
    for (int i = 0; i < 4; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = line[i*64 +: 64];
      tick();
    end
    burst_resp  = 1'b0;
    burst_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_total++;
    if ({burst_read, burst_write, pmem_resp} !== 3'b000)
      $display("FAIL reset_ctrl: got rd/wr/resp=%b want 000", {burst_read, burst_write, pmem_resp});
    else n_pass++;
    n_total++;
    if (burst_addr !== 32'h0 || burst_wdata !== 64'h0)
      $display("FAIL reset_bus: got addr=%h wdata=%h want 0/0", burst_addr, burst_wdata);
    else n_pass++;
    n_total++;
    if (pmem_rdata !== 256'h0)
      $display("FAIL reset_rdata: got %h want 0", pmem_rdata);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    logic [255:0] line;
    int           early_resp;
    line = {64'h4444444444444444, 64'h3333333333333333,
            64'h2222222222222222, 64'h1111111111111111};
    early_resp = 0;
    pmem_address = 32'h0000_1234;
    pmem_read    = 1'b1;
    tick();  // edge T: request accepted
    pmem_address = 32'hFFFF_FFFF;  // changes after acceptance must be ignored
    n_total++;
    if (burst_read !== 1'b1 || burst_write !== 1'b0)
      $display("FAIL fill_req: got rd=%b wr=%b want 1/0", burst_read, burst_write);
    else n_pass++;
    n_total++;
    if (burst_addr !== 32'h0000_1220)
      $display("FAIL fill_addr: got %h want 00001220", burst_addr);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = line[i*64 +: 64];
      tick();
      if (i < 3 && pmem_resp !== 1'b0) early_resp++;
    end
    burst_resp = 1'b0;
    n_total++;
    if (early_resp != 0)
      $display("FAIL fill_early_resp: got %0d early pulses want 0", early_resp);
    else n_pass++;
    n_total++;
    if (pmem_resp !== 1'b1 || burst_read !== 1'b0)
      $display("FAIL fill_done: got resp=%b rd=%b want 1/0", pmem_resp, burst_read);
    else n_pass++;
    n_total++;
    if (pmem_rdata !== line)
      $display("FAIL fill_rdata: got %h want %h", pmem_rdata, line);
    else n_pass++;
    pmem_read = 1'b0;
    tick();
    n_total++;
    if (pmem_resp !== 1'b0 || burst_read !== 1'b0)
      $display("FAIL fill_single_pulse: got resp=%b rd=%b want 0/0", pmem_resp, burst_read);
    else n_pass++;
  endtask

  task automatic test_writeback();
    logic [255:0] line;
    logic [255:0] prev_fill;
    logic [63:0]  exp_beat [4];
    line = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
    exp_beat[0] = 64'h8899AABBCCDDEEFF;
    exp_beat[1] = 64'h0011223344556677;
    exp_beat[2] = 64'hFEDCBA9876543210;
    exp_beat[3] = 64'h0123456789ABCDEF;
    prev_fill = {64'h4444444444444444, 64'h3333333333333333,
                 64'h2222222222222222, 64'h1111111111111111};
    pmem_address = 32'h8000_00FF;
    pmem_wdata   = line;
    pmem_write   = 1'b1;
    tick();
    pmem_wdata = '0;  // changes after acceptance must be ignored
    n_total++;
    if (burst_write !== 1'b1 || burst_read !== 1'b0 || burst_addr !== 32'h8000_00E0)
      $display("FAIL wb_req: got wr=%b rd=%b addr=%h want 1/0/800000e0", burst_write, burst_read, burst_addr);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (burst_wdata !== exp_beat[i])
        $display("FAIL wb_beat%0d: got %h want %h", i, burst_wdata, exp_beat[i]);
      else n_pass++;
      burst_resp = 1'b1;
      tick();
    end
    burst_resp = 1'b0;
    n_total++;
    if (burst_write !== 1'b0 || pmem_resp !== 1'b1)
      $display("FAIL wb_done: got wr=%b resp=%b want 0/1", burst_write, pmem_resp);
    else n_pass++;
    n_total++;
    if (pmem_rdata !== prev_fill)
      $display("FAIL wb_rdata_kept: got %h want %h", pmem_rdata, prev_fill);
    else n_pass++;
    pmem_write = 1'b0;
    tick();
    n_total++;
    if (pmem_resp !== 1'b0 || burst_write !== 1'b0)
      $display("FAIL wb_single_pulse: got resp=%b wr=%b want 0/0", pmem_resp, burst_write);
    else n_pass++;
  endtask

  task automatic test_waits();
    logic [255:0] line;
    logic [6:0]   pat;
    int           idx;
    int           early_resp;
    line = {64'hD3D3D3D3D3D3D3D3, 64'hC2C2C2C2C2C2C2C2,
            64'hB1B1B1B1B1B1B1B1, 64'hA0A0A0A0A0A0A0A0};
    pat  = 7'b1011001;  // bit 0 first: 1,0,0,1,1,0,1
    idx  = 0;
    early_resp = 0;
    pmem_address = 32'h0000_0040;
    pmem_read    = 1'b1;
    tick();
    for (int p = 0; p < 7; p++) begin
      burst_resp  = pat[p];
      burst_rdata = pat[p] ? line[idx*64 +: 64] : 64'hDEADDEADDEADDEAD;
      if (pat[p]) idx++;
      tick();
      if (p < 6 && pmem_resp !== 1'b0) early_resp++;
    end
    n_total++;
    if (early_resp != 0)
      $display("FAIL waits_early_resp: got %0d early pulses want 0", early_resp);
    else n_pass++;
    n_total++;
    if (pmem_resp !== 1'b1 || pmem_rdata !== line)
      $display("FAIL waits_done: got resp=%b rdata=%h want 1 %h", pmem_resp, pmem_rdata, line);
    else n_pass++;
    pmem_read = 1'b0;
    // A stray strobe in DONE must not be captured.
    burst_resp  = 1'b1;
    burst_rdata = 64'hBADBADBADBADBAD0;
    tick();
    burst_resp = 1'b0;
    n_total++;
    if (pmem_resp !== 1'b0 || pmem_rdata !== line)
      $display("FAIL waits_no_extra: got resp=%b rdata=%h want 0 %h", pmem_resp, pmem_rdata, line);
    else n_pass++;
    tick();
  endtask

  task automatic test_both();
    logic [255:0] wline;
    logic [255:0] rline;
    wline = {64'h0404040404040404, 64'h0303030303030303,
             64'h0202020202020202, 64'h0101010101010101};
    rline = {64'hF4F4F4F4F4F4F4F4, 64'hF3F3F3F3F3F3F3F3,
             64'hF2F2F2F2F2F2F2F2, 64'hF1F1F1F1F1F1F1F1};
    pmem_address = 32'h2000_0010;
    pmem_wdata   = wline;
    pmem_read    = 1'b1;
    pmem_write   = 1'b1;
    tick();
    n_total++;
    if (burst_write !== 1'b1 || burst_read !== 1'b0)
      $display("FAIL both_write_first: got wr=%b rd=%b want 1/0", burst_write, burst_read);
    else n_pass++;
    drive_beats(rline);  // strobes consumed as write beats
    n_total++;
    if (pmem_resp !== 1'b1 || burst_read !== 1'b0 || burst_write !== 1'b0)
      $display("FAIL both_done: got resp=%b rd=%b wr=%b want 1/0/0", pmem_resp, burst_read, burst_write);
    else n_pass++;
    pmem_write = 1'b0;  // the read stays high
    tick();
    n_total++;
    if (pmem_resp !== 1'b0 || burst_read !== 1'b0)
      $display("FAIL both_idle_gap: got resp=%b rd=%b want 0/0", pmem_resp, burst_read);
    else n_pass++;
    tick();
    n_total++;
    if (burst_read !== 1'b1 || burst_addr !== 32'h2000_0000)
      $display("FAIL both_fill_start: got rd=%b addr=%h want 1/20000000", burst_read, burst_addr);
    else n_pass++;
    drive_beats(rline);
    n_total++;
    if (pmem_resp !== 1'b1 || pmem_rdata !== rline)
      $display("FAIL both_fill_done: got resp=%b rdata=%h want 1 %h", pmem_resp, pmem_rdata, rline);
    else n_pass++;
    pmem_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [255:0] line;
    int           stray_resp;
    line = {64'h8888888888888888, 64'h7777777777777777,
            64'h6666666666666666, 64'h5555555555555555};
    stray_resp = 0;
    pmem_address = 32'h3000_0000;
    pmem_read    = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = line[i*64 +: 64];
      tick();
    end
    burst_resp = 1'b0;
    rst        = 1'b1;
    pmem_read  = 1'b0;
    tick();
    n_total++;
    if (burst_read !== 1'b0 || pmem_resp !== 1'b0)
      $display("FAIL rstmid_ctrl: got rd=%b resp=%b want 0/0", burst_read, pmem_resp);
    else n_pass++;
    n_total++;
    if (pmem_rdata !== 256'h0)
      $display("FAIL rstmid_rdata: got %h want 0", pmem_rdata);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pmem_resp !== 1'b0 || burst_read !== 1'b0) stray_resp++;
    end
    n_total++;
    if (stray_resp != 0)
      $display("FAIL rstmid_no_resp: got %0d active cycles want 0", stray_resp);
    else n_pass++;
    pmem_read = 1'b1;
    tick();
    drive_beats(line);
    n_total++;
    if (pmem_resp !== 1'b1 || pmem_rdata !== line)
      $display("FAIL rstmid_refill: got resp=%b rdata=%h want 1 %h", pmem_resp, pmem_rdata, line);
    else n_pass++;
    pmem_read = 1'b0;
    tick();
  endtask

  task automatic test_stray_resp();
    logic [255:0] prev;
    logic [255:0] line;
    prev = {64'h8888888888888888, 64'h7777777777777777,
            64'h6666666666666666, 64'h5555555555555555};
    line = {64'h9D9D9D9D9D9D9D9D, 64'h9C9C9C9C9C9C9C9C,
            64'h9B9B9B9B9B9B9B9B, 64'h9A9A9A9A9A9A9A9A};
    burst_resp  = 1'b1;
    burst_rdata = 64'hEEEEEEEEEEEEEEEE;
    for (int i = 0; i < 3; i++) tick();
    burst_resp = 1'b0;
    n_total++;
    if (pmem_rdata !== prev || burst_read !== 1'b0)
      $display("FAIL stray_idle: got rd=%b rdata=%h want 0 %h", burst_read, pmem_rdata, prev);
    else n_pass++;
    pmem_address = 32'h0000_0080;
    pmem_read    = 1'b1;
    tick();
    drive_beats(line);
    n_total++;
    if (pmem_resp !== 1'b1 || pmem_rdata !== line)
      $display("FAIL stray_fill: got resp=%b rdata=%h want 1 %h", pmem_resp, pmem_rdata, line);
    else n_pass++;
    pmem_read = 1'b0;
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    burst_rdata  = '0;
    burst_resp   = 1'b0;
    test_reset();
    test_fill();
    test_writeback();
    test_waits();
    test_both();
    test_reset_mid();
    test_stray_resp();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
